// File: rtl/mem_access_unit.sv
// mem_access_unit: executes one RISC-V style load or store at a time against a simple
// request/ready memory port.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   cpu_req/we/addr/     request from the core, sampled only when idle
//   cpu_wdata/cpu_funct3
//   cpu_rdata            aligned, extended load result (held until the next completed load)
//   cpu_done/cpu_err     one-cycle completion pulse and its error flag
//   busy                 high whenever a request is in progress
//   mem_req/we/addr/     registered memory request, held stable until mem_ready
//   mem_wdata/mem_be
//   mem_ready/mem_rdata  memory acceptance; read data valid in the same cycle
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_funct3,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    // The counter saturates one short of the limit: the cycle that would reach it aborts.
    localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [15:0] wait_cnt_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;

    logic        req_legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign busy = (state_q != StIdle);

    // Legality of the incoming request (size/sign encoding and natural alignment).
    always_comb begin
        req_legal = 1'b1;
        if (cpu_we) begin
            if (cpu_funct3 > 3'b010) req_legal = 1'b0;
        end else if (cpu_funct3 == 3'b011 || cpu_funct3 == 3'b110 || cpu_funct3 == 3'b111) begin
            req_legal = 1'b0;
        end
        if (cpu_funct3[1:0] == 2'b01 && cpu_addr[0]) req_legal = 1'b0;
        if (cpu_funct3[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00) req_legal = 1'b0;
    end

    // Store lane replication and byte enables; loads read the whole word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'h0;
        if (cpu_we) begin
            case (cpu_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << cpu_addr[1:0];
                    st_wdata = {4{cpu_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << {cpu_addr[1], 1'b0};
                    st_wdata = {2{cpu_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = cpu_wdata;
                end
            endcase
        end
    end

    // Load lane selection and extension using the latched address/size.
    always_comb begin
        ld_shift = mem_rdata >> {addr_lo_q, 3'b000};
        ld_half  = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 16'h0;
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
            cpu_rdata  <= 32'h0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    cpu_done <= 1'b0;
                    cpu_err  <= 1'b0;
                    if (cpu_req) begin
                        addr_lo_q <= cpu_addr[1:0];
                        funct3_q  <= cpu_funct3;
                        if (req_legal) begin
                            state_q    <= StAccess;
                            wait_cnt_q <= 16'h0;
                            mem_req    <= 1'b1;
                            mem_we     <= cpu_we;
                            mem_addr   <= {cpu_addr[31:2], 2'b00};
                            mem_be     <= st_be;
                            mem_wdata  <= st_wdata;
                        end else begin
                            // Illegal request completes without touching memory.
                            state_q  <= StDone;
                            cpu_done <= 1'b1;
                            cpu_err  <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    // mem_ready wins over a timeout reached in the same cycle.
                    if (mem_ready) begin
                        state_q  <= StDone;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b0;
                        if (!mem_we) cpu_rdata <= ld_data;
                    end else if (wait_cnt_q == WaitLast) begin
                        state_q  <= StDone;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'h1;
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    cpu_done <= 1'b0;
                    cpu_err  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_funct3(cpu_funct3),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_funct3 = f3;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", cpu_done); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) begin errors++; $display("FAIL reset_mem_bus: got %b %h %h %h want all 0", mem_we, mem_be, mem_addr, mem_wdata); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_lb_immediate();
        mem_ready = 1'b1;  // held high in idle: must be ignored
        mem_rdata = 32'h80FF_1234;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored: busy got %b want 0", busy); end
        request(1'b0, 32'h103, 32'h0, 3'b000);
        tick();
        cpu_req = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lb_mem_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lb_mem_addr: got %h want 00000100", mem_addr); end
        checks++; if (mem_be !== 4'hF || mem_we !== 1'b0) begin errors++; $display("FAIL lb_be_we: got %h %b want f 0", mem_be, mem_we); end
        checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL lb_early_done: got %b want 0", cpu_done); end
        tick();
        checks++; if (cpu_done !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL lb_done: got done=%b err=%b want 1 0", cpu_done, cpu_err); end
        checks++; if (cpu_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", cpu_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b want 0", mem_req); end
        tick();
        checks++; if (cpu_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lb_pulse: got done=%b busy=%b want 0 0", cpu_done, busy); end
        mem_ready = 1'b0;
    endtask

    task automatic test_sh_wait();
        request(1'b1, 32'h202, 32'h0000_ABCD, 3'b001);
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 ||
                mem_wdata !== 32'hABCD_ABCD || mem_addr !== 32'h200) begin
                errors++;
                $display("FAIL sh_hold[%0d]: got req=%b we=%b be=%b wd=%h a=%h want 1 1 1100 abcdabcd 200",
                         i, mem_req, mem_we, mem_be, mem_wdata, mem_addr);
            end
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (cpu_done !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL sh_done: got done=%b err=%b want 1 0", cpu_done, cpu_err); end
        checks++; if (cpu_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL sh_rdata_kept: got %h want ffffff80", cpu_rdata); end
        tick();
    endtask

    task automatic test_stores();
        logic [31:0] addr [3]  = '{32'h101, 32'h200, 32'h300};
        logic [31:0] wd   [3]  = '{32'h1234_5678, 32'h1111_BEEF, 32'hA5A5_5A5A};
        logic [2:0]  f3   [3]  = '{3'b000, 3'b001, 3'b010};
        logic [3:0]  ebe  [3]  = '{4'b0010, 4'b0011, 4'b1111};
        logic [31:0] ewd  [3]  = '{32'h7878_7878, 32'hBEEF_BEEF, 32'hA5A5_5A5A};
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            request(1'b1, addr[i], wd[i], f3[i]);
            tick();
            cpu_req = 1'b0;
            checks++;
            if (mem_be !== ebe[i] || mem_wdata !== ewd[i] || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL store[%0d]: got be=%b wd=%h req=%b want %b %h 1", i, mem_be, mem_wdata, mem_req, ebe[i], ewd[i]);
            end
            tick();
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_load_formats();
        logic [31:0] addr [5] = '{32'h10, 32'h12, 32'h11, 32'h12, 32'h14};
        logic [2:0]  f3   [5] = '{3'b001, 3'b101, 3'b100, 3'b000, 3'b010};
        logic [31:0] rd   [5] = '{32'h1234_F00D, 32'hABCD_1234, 32'h0000_C3AA, 32'h007F_0000, 32'hDEAD_BEEF};
        logic [31:0] exp  [5] = '{32'hFFFF_F00D, 32'h0000_ABCD, 32'h0000_00C3, 32'h0000_007F, 32'hDEAD_BEEF};
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_rdata = rd[i];
            request(1'b0, addr[i], 32'h0, f3[i]);
            tick();
            cpu_req = 1'b0;
            tick();
            checks++;
            if (cpu_rdata !== exp[i] || cpu_done !== 1'b1 || cpu_err !== 1'b0) begin
                errors++;
                $display("FAIL load[%0d]: got rdata=%h done=%b err=%b want %h 1 0", i, cpu_rdata, cpu_done, cpu_err, exp[i]);
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic        we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] addr [4] = '{32'h101, 32'h0, 32'h0, 32'h1};
        logic [2:0]  f3   [4] = '{3'b010, 3'b011, 3'b110, 3'b001};
        logic [31:0] keep;
        keep = cpu_rdata;
        for (int i = 0; i < 4; i++) begin
            request(we[i], addr[i], 32'hFFFF_FFFF, f3[i]);
            tick();
            cpu_req = 1'b0;
            checks++;
            if (cpu_done !== 1'b1 || cpu_err !== 1'b1 || mem_req !== 1'b0 || cpu_rdata !== keep) begin
                errors++;
                $display("FAIL illegal[%0d]: got done=%b err=%b req=%b rdata=%h want 1 1 0 %h",
                         i, cpu_done, cpu_err, mem_req, cpu_rdata, keep);
            end
            tick();
            checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL illegal_pulse[%0d]: got %b want 0", i, cpu_done); end
        end
    endtask

    task automatic test_timeout();
        request(1'b0, 32'h400, 32'h0, 3'b010);
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_req !== 1'b1 || cpu_done !== 1'b0) begin errors++; $display("FAIL to_wait[%0d]: got req=%b done=%b want 1 0", i, mem_req, cpu_done); end
            tick();
        end
        checks++; if (mem_req !== 1'b0 || cpu_done !== 1'b1 || cpu_err !== 1'b1) begin errors++; $display("FAIL to_abort: got req=%b done=%b err=%b want 0 1 1", mem_req, cpu_done, cpu_err); end
        tick();
        // Ready arriving on the last allowed wait cycle completes normally.
        mem_rdata = 32'h1234_5678;
        request(1'b0, 32'h404, 32'h0, 3'b010);
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (cpu_done !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL to_edge_ok: got done=%b err=%b want 1 0", cpu_done, cpu_err); end
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL to_edge_rdata: got %h want 12345678", cpu_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        request(1'b0, 32'h500, 32'h0, 3'b010);
        tick();
        cpu_req = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid: got req=%b busy=%b rdata=%h want 0 0 0", mem_req, busy, cpu_rdata); end
        tick();
        checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b want 0", cpu_done); end
        reset = 1'b1;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h8000_0000;
        request(1'b0, 32'h3, 32'h0, 3'b100);
        tick();
        cpu_req = 1'b0;
        tick();
        checks++; if (cpu_rdata !== 32'h0000_0080 || cpu_done !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL rst_lbu: got rdata=%h done=%b err=%b want 00000080 1 0", cpu_rdata, cpu_done, cpu_err); end
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        request(1'b0, 32'h600, 32'h0, 3'b010);
        tick();
        request(1'b1, 32'h700, 32'h5555_5555, 3'b000);  // must be ignored while busy
        tick();
        checks++; if (mem_addr !== 32'h600 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_req !== 1'b1) begin errors++; $display("FAIL busy_ignore: got a=%h we=%b be=%h req=%b want 600 0 f 1", mem_addr, mem_we, mem_be, mem_req); end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        cpu_req = 1'b0;
        mem_ready = 1'b0;
        checks++; if (cpu_done !== 1'b1 || cpu_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_done: got done=%b rdata=%h want 1 cafef00d", cpu_done, cpu_rdata); end
        tick();
        tick();
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL no_queue: got req=%b busy=%b want 0 0", mem_req, busy); end
    endtask

    initial begin
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        cpu_funct3 = 3'b000;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_lb_immediate();
        test_sh_wait();
        test_stores();
        test_load_formats();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles waiting for mem_ready before abort, range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 cpu_req  input  1  start a load/store; sampled only in IDLE.
REQ-005 cpu_we  input  1  1=store, 0=load.
REQ-006 cpu_addr  input  32  byte address.
REQ-007 cpu_wdata  input  32  store data, right-aligned.
REQ-008 cpu_funct3  input  3  access size/sign, RISC-V load/store encoding.
REQ-009 cpu_rdata  output  32  aligned, extended load result.
REQ-010 cpu_done  output  1  one-cycle completion pulse.
REQ-011 cpu_err  output  1  completion had error; valid with cpu_done.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 mem_req  output  1  memory request, held until accepted.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_addr  output  32  word address, {cpu_addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_ready  input  1  memory accepted request; read data valid same cycle.
REQ-019 mem_rdata  input  32  memory read word.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE; all mem_* outputs and cpu_rdata SHALL be registered.
REQ-021 IDLE with cpu_req=1: latch we/addr/wdata/funct3, check legality, go ACCESS (legal) or DONE with err (illegal).
REQ-022 Illegal: load funct3 in {011,110,111}; store funct3 > 010; halfword with addr[0]=1; word with addr[1:0]!=00; no memory request issued.
REQ-023 ACCESS: mem_req=1 and mem_we/mem_addr/mem_be/mem_wdata held stable every cycle until mem_ready=1.
REQ-024 ACCESS with mem_ready=1: drop mem_req next cycle, capture and format mem_rdata (loads), go DONE with err=0.
REQ-025 DONE: cpu_done=1 for exactly one cycle, then IDLE; minimum latency cpu_req to cpu_done = 2 cycles when mem_ready is already high.
REQ-026 Store enables: SB -> 4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH -> 4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; SW -> 4'b1111, wdata unchanged.
REQ-027 Loads: mem_we=0, mem_be=4'b1111; byte/half selected by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-028 cpu_rdata SHALL hold its value until the next completed load; stores and errors leave it unchanged.
REQ-029 16-bit wait counter cleared on ACCESS entry, incremented per ACCESS cycle without mem_ready; at TIMEOUT_CYCLES waits: drop mem_req, go DONE with err=1.
REQ-030 mem_ready in the same cycle the counter reaches the limit SHALL complete normally (err=0).
REQ-031 cpu_req while busy=1 SHALL be ignored; no queueing.
REQ-032 mem_ready outside ACCESS SHALL be ignored.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_done=0, cpu_err=0, busy=0.
REQ-034 Reset during ACCESS SHALL abandon the transaction with no cpu_done pulse; first request after release behaves as from cold reset.

Verification
REQ-035 LB addr=0x103, mem_rdata=0x80FF_1234, mem_ready immediate -> mem_addr=0x100, mem_be=4'hF, cpu_rdata=0xFFFF_FF80, cpu_done 2 cycles after cpu_req, err=0.
REQ-036 SH addr=0x202, wdata=0x0000_ABCD, mem_ready after 3 wait cycles -> mem_be=4'b1100, mem_wdata=0xABCD_ABCD stable 4 cycles, done err=0.
REQ-037 LW addr=0x101 -> no mem_req, cpu_done with err=1 one cycle after request, cpu_rdata unchanged.
REQ-038 TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req high 4 cycles then low, cpu_done err=1; mem_ready asserted on 4th wait cycle -> err=0.
REQ-039 reset pulsed low mid-ACCESS -> mem_req=0 within same cycle, no cpu_done; next LBU addr=0x3, mem_rdata=0x8000_0000 -> cpu_rdata=0x0000_0080.
REQ-040 cpu_req re-asserted during ACCESS with different addr -> ignored, first transaction's outputs unchanged.
